// File: rtl/mov_sprite_pkg.sv
// -----------------------------------------------------------------------------
// mov_sprite_pkg
// Shared definitions for the moving-sprite engine:
//   - COLOR_TRANSPARENT : colour index that never wins compositing
//   - texel_idx_w()     : bits needed to index one texel row/column
//   - rom_addr_w()      : width of the {char, frame, row, col} texel address
//   - sprite_cfg_t      : one sprite's configuration record
//   - texel_pattern()   : built-in texel image served by the channel ROMs
// The record field widths are fixed here; the engine's COORD_W and CHAR_W
// parameters must equal SPR_COORD_W and SPR_CHAR_W.
// -----------------------------------------------------------------------------
package mov_sprite_pkg;

    localparam int SPR_COORD_W       = 10;
    localparam int SPR_CHAR_W        = 4;
    localparam int COLOR_TRANSPARENT = 0;

    function automatic int texel_idx_w(input int sprite_w);
        return $clog2(sprite_w);
    endfunction

    function automatic int rom_addr_w(input int char_w, input int frame_w,
                                      input int sprite_w);
        return char_w + frame_w + 2 * $clog2(sprite_w);
    endfunction

    typedef struct packed {
        logic [SPR_COORD_W-1:0] x;       // left edge, screen pixels
        logic [SPR_COORD_W-1:0] y;       // top edge, screen pixels
        logic [SPR_CHAR_W-1:0]  chr;     // character select
        logic                   dir;     // facing, 1 = left
        logic                   mirror;  // mirror enable
        logic                   en;      // visible
        logic                   anim;    // animation enable
    } sprite_cfg_t;

    // Texel image: a diagonal stripe pattern that differs per character and
    // per animation frame. The caller truncates the result to COLOR_W bits.
    function automatic int texel_pattern(input int chr, input int frame,
                                         input int row, input int col);
        return chr + 2 * col + row + 2 * frame;
    endfunction

endpackage

// File: rtl/mov_sprite_channel.sv
// -----------------------------------------------------------------------------
// mov_sprite_channel
// One sprite channel: double-buffered configuration (shadow/active), per-sprite
// animation counters, stage-0 hit test and texel addressing, and the
// synchronous texel ROM (stage 1).
// Ports:
//   clock, resetn  : clock and async active-low reset
//   cfg_we         : write strobe, already qualified for this channel
//   cfg            : new configuration record
//   frame_tick     : commits shadow to active and advances animation
//   scan_x, scan_y : current scan coordinate
//   in_q           : registered "scan pixel lies inside this sprite"
//   texel_q        : registered texel colour index for the scan pixel
// -----------------------------------------------------------------------------
module mov_sprite_channel
    import mov_sprite_pkg::*;
#(
    parameter int SPRITE_W   = 16,
    parameter int SCALE_LOG2 = 2,
    parameter int CHAR_W     = 4,
    parameter int FRAME_W    = 1,
    parameter int ANIM_DIV   = 8,
    parameter int COORD_W    = 10,
    parameter int COLOR_W    = 2
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               cfg_we,
    input  sprite_cfg_t        cfg,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] scan_x,
    input  logic [COORD_W-1:0] scan_y,
    output logic               in_q,
    output logic [COLOR_W-1:0] texel_q
);

    localparam int IDX_W  = texel_idx_w(SPRITE_W);
    localparam int ADDR_W = rom_addr_w(CHAR_W, FRAME_W, SPRITE_W);
    localparam int SPAN   = SPRITE_W << SCALE_LOG2;
    localparam int DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    sprite_cfg_t        shadow_q;
    sprite_cfg_t        active_q;
    sprite_cfg_t        shadow_next;
    logic [FRAME_W-1:0] frame_q;
    logic [DIV_W-1:0]   div_q;

    // A write in the same cycle as frame_tick is folded into the commit.
    always_comb begin
        shadow_next = cfg_we ? cfg : shadow_q;
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_next;
            if (frame_tick) begin
                active_q <= shadow_next;
            end
        end
    end

    // Animation reads active_q.anim before this tick's commit lands.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_q   <= '0;
            frame_q <= '0;
        end else if (frame_tick && active_q.anim) begin
            if (div_q == DIV_W'(ANIM_DIV - 1)) begin
                div_q   <= '0;
                frame_q <= frame_q + FRAME_W'(1);
            end else begin
                div_q   <= div_q + DIV_W'(1);
            end
        end
    end

    // Stage 0: modular offsets; a pixel left of / above the sprite wraps to a
    // large unsigned offset and fails the span compare.
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic               hit_s0;
    logic [IDX_W-1:0]   col;
    logic [IDX_W-1:0]   row;
    logic [IDX_W-1:0]   col_eff;
    logic [ADDR_W-1:0]  rom_addr;

    always_comb begin
        dx       = scan_x - active_q.x;
        dy       = scan_y - active_q.y;
        hit_s0   = active_q.en && (dx < COORD_W'(SPAN)) && (dy < COORD_W'(SPAN));
        col      = dx[SCALE_LOG2 +: IDX_W];
        row      = dy[SCALE_LOG2 +: IDX_W];
        col_eff  = (active_q.dir ^ active_q.mirror) ? (IDX_W'(SPRITE_W - 1) - col) : col;
        rom_addr = {active_q.chr, frame_q, row, col_eff};
    end

    // Stage 1: synchronous texel ROM, address fields unpacked for the pattern.
    logic [CHAR_W-1:0]  rom_chr;
    logic [FRAME_W-1:0] rom_frame;
    logic [IDX_W-1:0]   rom_row;
    logic [IDX_W-1:0]   rom_col;

    always_comb begin
        rom_col   = rom_addr[IDX_W-1:0];
        rom_row   = rom_addr[2*IDX_W-1:IDX_W];
        rom_frame = rom_addr[2*IDX_W +: FRAME_W];
        rom_chr   = rom_addr[ADDR_W-1 -: CHAR_W];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            in_q    <= 1'b0;
            texel_q <= '0;
        end else begin
            in_q    <= hit_s0;
            texel_q <= COLOR_W'(texel_pattern(int'(rom_chr), int'(rom_frame),
                                              int'(rom_row), int'(rom_col)));
        end
    end

endmodule

// File: rtl/mov_sprite_engine.sv
// -----------------------------------------------------------------------------
// mov_sprite_engine
// NUM_SPRITES moving sprites composited per scan pixel with fixed priority
// (lowest index wins among opaque texels). Two-cycle latency, one pixel per
// clock, no backpressure.
// Ports:
//   clock, resetn       : clock and async active-low reset
//   cfg_we, cfg_sel     : configuration write strobe and target sprite
//   cfg_x, cfg_y        : sprite top-left corner, screen pixels
//   cfg_char            : character select
//   cfg_dir, cfg_mirror : facing (1 = left) and mirror; either flips columns
//   cfg_en, cfg_anim    : visible, animation enable
//   frame_tick          : start of vertical blank; commits configuration
//   scan_valid          : scan coordinate valid
//   scan_x, scan_y      : scan coordinate
//   pix_valid           : scan_valid delayed two clocks
//   pix_hit             : an opaque sprite texel covers this pixel
//   pix_id              : winning sprite index (0 when no hit)
//   pix_out             : winning colour index (0 when no hit)
// -----------------------------------------------------------------------------
module mov_sprite_engine
    import mov_sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 16,
    parameter int SCALE_LOG2  = 2,
    parameter int CHAR_W      = 4,
    parameter int FRAME_W     = 1,
    parameter int ANIM_DIV    = 8,
    parameter int COORD_W     = 10,
    parameter int COLOR_W     = 2,
    localparam int SEL_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               cfg_we,
    input  logic [SEL_W-1:0]   cfg_sel,
    input  logic [COORD_W-1:0] cfg_x,
    input  logic [COORD_W-1:0] cfg_y,
    input  logic [CHAR_W-1:0]  cfg_char,
    input  logic               cfg_dir,
    input  logic               cfg_mirror,
    input  logic               cfg_en,
    input  logic               cfg_anim,
    input  logic               frame_tick,
    input  logic               scan_valid,
    input  logic [COORD_W-1:0] scan_x,
    input  logic [COORD_W-1:0] scan_y,
    output logic               pix_valid,
    output logic               pix_hit,
    output logic [SEL_W-1:0]   pix_id,
    output logic [COLOR_W-1:0] pix_out
);

    sprite_cfg_t cfg_word;

    always_comb begin
        cfg_word.x      = cfg_x;
        cfg_word.y      = cfg_y;
        cfg_word.chr    = cfg_char;
        cfg_word.dir    = cfg_dir;
        cfg_word.mirror = cfg_mirror;
        cfg_word.en     = cfg_en;
        cfg_word.anim   = cfg_anim;
    end

    logic [NUM_SPRITES-1:0] in_s1;
    logic [COLOR_W-1:0]     texel_s1 [NUM_SPRITES];
    logic                   valid_s1;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_chan
        mov_sprite_channel #(
            .SPRITE_W   (SPRITE_W),
            .SCALE_LOG2 (SCALE_LOG2),
            .CHAR_W     (CHAR_W),
            .FRAME_W    (FRAME_W),
            .ANIM_DIV   (ANIM_DIV),
            .COORD_W    (COORD_W),
            .COLOR_W    (COLOR_W)
        ) u_chan (
            .clock      (clock),
            .resetn     (resetn),
            .cfg_we     (cfg_we && (cfg_sel == SEL_W'(i))),
            .cfg        (cfg_word),
            .frame_tick (frame_tick),
            .scan_x     (scan_x),
            .scan_y     (scan_y),
            .in_q       (in_s1[i]),
            .texel_q    (texel_s1[i])
        );
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_s1 <= 1'b0;
        end else begin
            valid_s1 <= scan_valid;
        end
    end

    // Stage 2: priority mux. Scanning from the highest index down lets the
    // lowest opaque index overwrite and win.
    logic               hit_d;
    logic [SEL_W-1:0]   id_d;
    logic [COLOR_W-1:0] out_d;

    // NOTE: every always_comb output gets a default before any condition so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        hit_d = 1'b0;
        id_d  = '0;
        out_d = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (valid_s1 && in_s1[i] && (texel_s1[i] != COLOR_W'(COLOR_TRANSPARENT))) begin
                hit_d = 1'b1;
                id_d  = SEL_W'(i);
                out_d = texel_s1[i];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pix_valid <= 1'b0;
            pix_hit   <= 1'b0;
            pix_id    <= '0;
            pix_out   <= '0;
        end else begin
            pix_valid <= valid_s1;
            pix_hit   <= hit_d;
            pix_id    <= id_d;
            pix_out   <= out_d;
        end
    end

endmodule

// File: tb/tb_mov_sprite_engine.sv
// -----------------------------------------------------------------------------
// tb_mov_sprite_engine
// Directed bench for mov_sprite_engine with default parameters. Expected
// texels come from the bench's own copy of the texel image:
//   texel = (char + 2*col + row + 2*frame) mod 4
// -----------------------------------------------------------------------------
module tb_mov_sprite_engine;

    logic       clock = 1'b0;
    logic       resetn;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [9:0] cfg_x;
    logic [9:0] cfg_y;
    logic [3:0] cfg_char;
    logic       cfg_dir;
    logic       cfg_mirror;
    logic       cfg_en;
    logic       cfg_anim;
    logic       frame_tick;
    logic       scan_valid;
    logic [9:0] scan_x;
    logic [9:0] scan_y;
    logic       pix_valid;
    logic       pix_hit;
    logic [1:0] pix_id;
    logic [1:0] pix_out;

    int checks = 0;
    int errors = 0;

    mov_sprite_engine dut (
        .clock      (clock),
        .resetn     (resetn),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_x      (cfg_x),
        .cfg_y      (cfg_y),
        .cfg_char   (cfg_char),
        .cfg_dir    (cfg_dir),
        .cfg_mirror (cfg_mirror),
        .cfg_en     (cfg_en),
        .cfg_anim   (cfg_anim),
        .frame_tick (frame_tick),
        .scan_valid (scan_valid),
        .scan_x     (scan_x),
        .scan_y     (scan_y),
        .pix_valid  (pix_valid),
        .pix_hit    (pix_hit),
        .pix_id     (pix_id),
        .pix_out    (pix_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int tex(input int chr, input int frm, input int row, input int col);
        return (chr + 2 * col + row + 2 * frm) % 4;
    endfunction

    task automatic cfg_write(input int sel, input int x, input int y, input int chr,
                             input int dir, input int mir, input int en, input int anim,
                             input int tick);
        @(negedge clock);
        cfg_sel    = 2'(sel);
        cfg_x      = 10'(x);
        cfg_y      = 10'(y);
        cfg_char   = 4'(chr);
        cfg_dir    = 1'(dir);
        cfg_mirror = 1'(mir);
        cfg_en     = 1'(en);
        cfg_anim   = 1'(anim);
        cfg_we     = 1'b1;
        frame_tick = 1'(tick);
        @(negedge clock);
        cfg_we     = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            frame_tick = 1'b1;
            @(negedge clock);
            frame_tick = 1'b0;
        end
    endtask

    // Present one scan pixel and compare the outputs two clocks later.
    task automatic scan_check(input string tag, input int x, input int y,
                              input int exp_hit, input int exp_id, input int exp_out);
        @(negedge clock);
        scan_x     = 10'(x);
        scan_y     = 10'(y);
        scan_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        scan_valid = 1'b0;
        @(posedge clock);
        #1;
        check({tag, ".valid"}, int'(pix_valid), 1);
        check({tag, ".hit"},   int'(pix_hit),   exp_hit);
        check({tag, ".id"},    int'(pix_id),    exp_id);
        check({tag, ".out"},   int'(pix_out),   exp_out);
    endtask

    initial begin
        resetn     = 1'b0;
        cfg_we     = 1'b0;
        cfg_sel    = '0;
        cfg_x      = '0;
        cfg_y      = '0;
        cfg_char   = '0;
        cfg_dir    = 1'b0;
        cfg_mirror = 1'b0;
        cfg_en     = 1'b0;
        cfg_anim   = 1'b0;
        frame_tick = 1'b0;
        scan_valid = 1'b0;
        scan_x     = '0;
        scan_y     = '0;

        repeat (3) @(posedge clock);
        #1;
        check("rst.valid", int'(pix_valid), 0);
        check("rst.hit",   int'(pix_hit),   0);
        check("rst.id",    int'(pix_id),    0);
        check("rst.out",   int'(pix_out),   0);
        @(negedge clock);
        resetn = 1'b1;

        // Shadow write only: nothing visible until frame_tick.
        cfg_write(0, 40, 20, 3, 0, 0, 1, 0, 0);
        scan_check("precommit", 40, 20, 0, 0, 0);
        ticks(1);

        // Basic hit, edges and scale.
        scan_check("origin",     40, 20, 1, 0, tex(3, 0, 0, 0));
        scan_check("right_edge", 103, 20, 1, 0, tex(3, 0, 0, 15));
        scan_check("right_out",  104, 20, 0, 0, 0);
        scan_check("left_out",   39, 20, 0, 0, 0);
        scan_check("bot_edge",   40, 83, 1, 0, tex(3, 0, 15, 0));
        scan_check("bot_out",    40, 84, 0, 0, 0);
        scan_check("scale_col1", 44, 20, 1, 0, tex(3, 0, 0, 1));
        scan_check("transp",     48, 24, 0, 0, 0);

        // Facing / mirror (write-through commits).
        cfg_write(0, 40, 20, 3, 1, 0, 1, 0, 1);
        scan_check("dir_col15", 40, 20, 1, 0, tex(3, 0, 0, 15));
        scan_check("dir_col14", 44, 20, 1, 0, tex(3, 0, 0, 14));
        cfg_write(0, 40, 20, 3, 1, 1, 1, 0, 1);
        scan_check("dirmir_col0", 40, 20, 1, 0, tex(3, 0, 0, 0));
        cfg_write(0, 40, 20, 3, 0, 1, 1, 0, 1);
        scan_check("mir_col15", 40, 20, 1, 0, tex(3, 0, 0, 15));
        cfg_write(0, 40, 20, 3, 0, 0, 0, 0, 1);

        // Double buffering on sprite 1.
        cfg_write(1, 200, 300, 3, 0, 0, 1, 0, 1);
        scan_check("db_old", 200, 300, 1, 1, tex(3, 0, 0, 0));
        cfg_write(1, 100, 300, 3, 0, 0, 1, 0, 0);
        scan_check("db_old_kept", 200, 300, 1, 1, tex(3, 0, 0, 0));
        scan_check("db_new_hidden", 100, 300, 0, 0, 0);
        ticks(1);
        scan_check("db_new", 100, 300, 1, 1, tex(3, 0, 0, 0));
        scan_check("db_old_gone", 200, 300, 0, 0, 0);
        cfg_write(1, 500, 300, 3, 0, 0, 1, 0, 1);
        scan_check("db_thru", 500, 300, 1, 1, tex(3, 0, 0, 0));
        scan_check("db_thru_old", 100, 300, 0, 0, 0);

        // Coordinate wrap across 1023 -> 0.
        cfg_write(1, 1020, 300, 3, 0, 0, 1, 0, 1);
        scan_check("wrap_lo", 2, 300, 1, 1, tex(3, 0, 0, 1));
        scan_check("wrap_hi", 1020, 300, 1, 1, tex(3, 0, 0, 0));
        cfg_write(1, 1020, 300, 3, 0, 0, 0, 0, 1);

        // Priority and transparency: sprites 0, 2, 3 stacked.
        cfg_write(0, 600, 100, 4, 0, 0, 1, 0, 0);
        cfg_write(2, 600, 100, 2, 0, 0, 1, 0, 0);
        cfg_write(3, 600, 100, 1, 0, 0, 1, 0, 1);
        scan_check("prio_transp0", 600, 100, 1, 2, 2);
        cfg_write(0, 600, 100, 1, 0, 0, 1, 0, 1);
        scan_check("prio_opaque0", 600, 100, 1, 0, 1);

        // Invalid slot over a covered pixel.
        @(negedge clock);
        scan_x     = 10'd600;
        scan_y     = 10'd100;
        scan_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("idle.valid", int'(pix_valid), 0);
        check("idle.hit",   int'(pix_hit),   0);
        check("idle.out",   int'(pix_out),   0);

        cfg_write(0, 600, 100, 1, 0, 0, 0, 0, 0);
        cfg_write(2, 600, 100, 2, 0, 0, 0, 0, 0);
        cfg_write(3, 600, 100, 1, 0, 0, 0, 0, 1);

        // Animation on sprite 3; the enabling tick itself does not count.
        cfg_write(3, 700, 400, 3, 0, 0, 1, 1, 1);
        scan_check("anim_t0", 700, 400, 1, 3, tex(3, 0, 0, 0));
        ticks(7);
        scan_check("anim_t7", 700, 400, 1, 3, tex(3, 0, 0, 0));
        ticks(1);
        scan_check("anim_t8", 700, 400, 1, 3, tex(3, 1, 0, 0));
        ticks(7);
        scan_check("anim_t15", 700, 400, 1, 3, tex(3, 1, 0, 0));
        ticks(1);
        scan_check("anim_t16", 700, 400, 1, 3, tex(3, 0, 0, 0));
        ticks(8);
        scan_check("anim_t24", 700, 400, 1, 3, tex(3, 1, 0, 0));
        // Disabling tick still counts (divider -> 1); afterwards frame holds.
        cfg_write(3, 700, 400, 3, 0, 0, 1, 0, 1);
        ticks(10);
        scan_check("hold_t10", 700, 400, 1, 3, tex(3, 1, 0, 0));
        ticks(10);
        scan_check("hold_t20", 700, 400, 1, 3, tex(3, 1, 0, 0));
        cfg_write(3, 700, 400, 3, 0, 0, 0, 0, 1);

        // Reset asserted while a hit streams out.
        cfg_write(0, 40, 20, 3, 0, 0, 1, 0, 1);
        @(negedge clock);
        scan_x     = 10'd40;
        scan_y     = 10'd20;
        scan_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("stream.hit", int'(pix_hit), 1);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("midrst.valid", int'(pix_valid), 0);
        check("midrst.hit",   int'(pix_hit),   0);
        check("midrst.id",    int'(pix_id),    0);
        check("midrst.out",   int'(pix_out),   0);
        @(negedge clock);
        scan_valid = 1'b0;
        resetn     = 1'b1;
        scan_check("post_rst", 40, 20, 0, 0, 0);
        cfg_write(0, 40, 20, 3, 0, 0, 1, 0, 0);
        scan_check("post_rst_cfg", 40, 20, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
